// File: rtl/spindle_cfg_scheduler.sv
// rtl/spindle_cfg_scheduler.sv - frame-aligned atomic commit of host parameter writes
module spindle_cfg_scheduler #(
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 16,
    parameter int CW        = 8
) (
    input  logic                     sim_clk,
    input  logic                     reset_global,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [2:0]               wr_addr,
    input  logic [31:0]              wr_data,
    input  logic                     force_commit,
    output logic [255:0]             cfg_out,
    output logic [$clog2(DEPTH):0]   pending_cnt,
    output logic                     frame_tick,
    output logic                     commit_done,
    output logic [7:0]               cfg_epoch
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    typedef enum logic {IDLE, COMMIT} state_t;

    function automatic logic [31:0] cfg_default(input logic [2:0] k);
        case (k)
            3'd0:    return 32'h3F66_6666;
            3'd1:    return 32'h3F66_6666;
            3'd2:    return 32'h0000_0000;
            3'd3:    return 32'h42A0_0000;
            3'd4:    return 32'h42A0_0000;
            3'd5:    return 32'h0000_0001;
            3'd6:    return 32'h3E71_4120;
            default: return 32'h3D14_4674;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     frame_cnt_q, frame_cnt_d;
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        addr_mem_q [DEPTH];
    logic [2:0]        addr_mem_d [DEPTH];
    logic [31:0]       data_mem_q [DEPTH];
    logic [31:0]       data_mem_d [DEPTH];
    logic [31:0]       cfg_q [8];
    logic [31:0]       cfg_d [8];
    logic              done_q, done_d;
    logic [7:0]        epoch_q, epoch_d;
    logic              push;

    assign wr_ready    = (state_q == IDLE) && (cnt_q < CNT_W'(DEPTH));
    assign frame_tick  = (frame_cnt_q == CW'(FRAME_LEN - 1));
    assign push        = wr_valid & wr_ready;
    assign pending_cnt = cnt_q;
    assign commit_done = done_q;
    assign cfg_epoch   = epoch_q;

    for (genvar k = 0; k < 8; k++) begin : g_cfg
        assign cfg_out[32*k +: 32] = cfg_q[k];
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_tick ? '0 : frame_cnt_q + CW'(1);
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        addr_mem_d  = addr_mem_q;
        data_mem_d  = data_mem_q;
        cfg_d       = cfg_q;
        done_d      = 1'b0;
        epoch_d     = epoch_q;
        case (state_q)
            IDLE: begin
                if (push) begin
                    addr_mem_d[tail_q] = wr_addr;
                    data_mem_d[tail_q] = wr_data;
                    tail_d             = tail_q + AW'(1);
                    cnt_d              = cnt_q + CNT_W'(1);
                end
                // a push on the triggering edge joins this commit
                if ((frame_tick || force_commit) && (cnt_q != '0 || push))
                    state_d = COMMIT;
            end
            default: begin
                cfg_d[addr_mem_q[head_q]] = data_mem_q[head_q];
                head_d = head_q + AW'(1);
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    epoch_d = epoch_q + 8'd1;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge sim_clk or posedge reset_global) begin
        if (reset_global) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            epoch_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
            for (int k = 0; k < 8; k++) cfg_q[k] <= cfg_default(3'(k));
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            epoch_q     <= epoch_d;
            addr_mem_q  <= addr_mem_d;
            data_mem_q  <= data_mem_d;
            cfg_q       <= cfg_d;
        end
    end
endmodule

// File: tb/tb_spindle_cfg_scheduler.sv
// tb/tb_spindle_cfg_scheduler.sv - self-checking bench for spindle_cfg_scheduler
module tb_spindle_cfg_scheduler;
    localparam int DEPTH = 4;
    localparam int FL    = 16;

    logic         sim_clk = 1'b0;
    logic         reset_global = 1'b1;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [2:0]   wr_addr = '0;
    logic [31:0]  wr_data = '0;
    logic         force_commit = 1'b0;
    logic [255:0] cfg_out;
    logic [2:0]   pending_cnt;
    logic         frame_tick;
    logic         commit_done;
    logic [7:0]   cfg_epoch;

    spindle_cfg_scheduler #(.DEPTH(DEPTH), .FRAME_LEN(FL), .CW(8)) dut (
        .sim_clk(sim_clk), .reset_global(reset_global), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .force_commit(force_commit), .cfg_out(cfg_out), .pending_cnt(pending_cnt),
        .frame_tick(frame_tick), .commit_done(commit_done), .cfg_epoch(cfg_epoch)
    );

    always #5 sim_clk = ~sim_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pending writes as a queue, a commit drains it one entry per edge
    typedef struct packed {logic [2:0] a; logic [31:0] d;} ent_t;
    ent_t        m_q[$];
    bit          m_drain, m_done, m_push;
    int          m_frame, m_epoch;
    logic [31:0] m_cfg [8];

    function automatic logic [31:0] def_val(input int k);
        logic [31:0] t [8] = '{32'h3F66_6666, 32'h3F66_6666, 32'h0, 32'h42A0_0000,
                               32'h42A0_0000, 32'h1, 32'h3E71_4120, 32'h3D14_4674};
        return t[k];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_drain = 0; m_done = 0; m_push = 0; m_frame = 0; m_epoch = 0;
        for (int k = 0; k < 8; k++) m_cfg[k] = def_val(k);
    endtask

    function automatic bit m_ready();
        return !m_drain && (m_q.size() < DEPTH);
    endfunction

    task automatic model_step(input bit v, input logic [2:0] a, input logic [31:0] d, input bit f);
        bit tk = (m_frame == FL - 1);
        ent_t e;
        m_push = v && m_ready();
        m_done = 0;
        if (m_drain) begin
            e = m_q.pop_front();
            m_cfg[e.a] = e.d;
            if (m_q.size() == 0) begin
                m_drain = 0;
                m_epoch = (m_epoch + 1) % 256;
                m_done  = 1;
            end
        end else begin
            if (m_push) m_q.push_back({a, d});
            if ((tk || f) && m_q.size() > 0) m_drain = 1;
        end
        m_frame = (m_frame + 1) % FL;
    endtask

    task automatic compare_all();
        logic [255:0] exp_cfg;
        for (int k = 0; k < 8; k++) exp_cfg[32*k +: 32] = m_cfg[k];
        chk("cfg_out", cfg_out, exp_cfg);
        chk("wr_ready", 256'(wr_ready), 256'(m_ready()));
        chk("pending_cnt", 256'(pending_cnt), 256'(m_q.size()));
        chk("frame_tick", 256'(frame_tick), 256'(m_frame == FL - 1));
        chk("commit_done", 256'(commit_done), 256'(m_done));
        chk("cfg_epoch", 256'(cfg_epoch), 256'(m_epoch));
    endtask

    task automatic cycle();
        @(posedge sim_clk);
        model_step(wr_valid, wr_addr, wr_data, force_commit);
        #1;
        compare_all();
    endtask

    task automatic push(input logic [2:0] a, input logic [31:0] d);
        int n = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        do begin cycle(); n++; end while (!m_push && n < 100);
        wr_valid = 1'b0;
        chk("push_accepted", 256'(m_push), 256'(1));
    endtask

    task automatic wait_frame(input int f);
        int n = 0;
        while (m_frame != f && n < 40) begin cycle(); n++; end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!commit_done && n < 60) begin cycle(); n++; end
        chk("commit_done_seen", 256'(commit_done), 256'(1));
    endtask

    function automatic logic [31:0] reg_of(input int k);
        return cfg_out[32*k +: 32];
    endfunction

    typedef struct {logic [2:0] a; logic [31:0] exp;} def_t;
    typedef struct {logic [2:0] a; logic [31:0] d; logic [31:0] exp;} vec_t;
    def_t defs [8];
    vec_t vecs [6];

    initial begin
        defs = '{'{3'd0, 32'h3F66_6666}, '{3'd1, 32'h3F66_6666}, '{3'd2, 32'h0},
                 '{3'd3, 32'h42A0_0000}, '{3'd4, 32'h42A0_0000}, '{3'd5, 32'h1},
                 '{3'd6, 32'h3E71_4120}, '{3'd7, 32'h3D14_4674}};
        vecs = '{'{3'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF}, '{3'd7, 32'h0000_0000, 32'h0000_0000},
                 '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, '{3'd5, 32'h0000_0002, 32'h0000_0002},
                 '{3'd2, 32'h8000_0001, 32'h8000_0001}, '{3'd6, 32'h1234_5678, 32'h1234_5678}};
        model_reset();
        repeat (2) @(posedge sim_clk);
        #1 reset_global = 1'b0;

        // reset state
        for (int i = 0; i < 8; i++) chk("reset_cfg", 256'(reg_of(int'(defs[i].a))), 256'(defs[i].exp));
        chk("reset_wr_ready", 256'(wr_ready), 256'(1));
        chk("reset_epoch", 256'(cfg_epoch), 256'(0));
        chk("reset_pending", 256'(pending_cnt), 256'(0));

        // frame-aligned commit
        wait_frame(2);
        push(3'd3, 32'h4248_0000);
        wait_frame(15);
        chk("tick_cfg3_old", 256'(reg_of(3)), 256'(32'h42A0_0000));
        cycle();
        chk("commit_cycle_cfg3_old", 256'(reg_of(3)), 256'(32'h42A0_0000));
        chk("commit_cycle_ready", 256'(wr_ready), 256'(0));
        cycle();
        chk("frame_cfg3_new", 256'(reg_of(3)), 256'(32'h4248_0000));
        chk("frame_done", 256'(commit_done), 256'(1));
        chk("frame_epoch", 256'(cfg_epoch), 256'(1));
        cycle();
        chk("frame_done_once", 256'(commit_done), 256'(0));

        // overwrite ordering
        push(3'd2, 32'd5); push(3'd2, 32'd9); push(3'd5, 32'd3);
        chk("ovr_pending3", 256'(pending_cnt), 256'(3));
        wait_done();
        chk("ovr_cfg2", 256'(reg_of(2)), 256'(32'd9));
        chk("ovr_cfg5", 256'(reg_of(5)), 256'(32'd3));
        chk("ovr_pending0", 256'(pending_cnt), 256'(0));
        chk("ovr_epoch", 256'(cfg_epoch), 256'(2));
        repeat (3) begin cycle(); chk("ovr_cfg2_hold", 256'(reg_of(2)), 256'(32'd9)); end

        // full FIFO, fifth write held across the commit
        push(3'd0, 32'h1111); push(3'd1, 32'h2222); push(3'd2, 32'h3333); push(3'd3, 32'h4444);
        chk("full_ready", 256'(wr_ready), 256'(0));
        chk("full_pending", 256'(pending_cnt), 256'(4));
        push(3'd7, 32'h5555);
        chk("full_epoch_mid", 256'(cfg_epoch), 256'(3));
        wait_done();
        chk("full_epoch", 256'(cfg_epoch), 256'(4));
        chk("full_cfg0", 256'(reg_of(0)), 256'(32'h1111));
        chk("full_cfg3", 256'(reg_of(3)), 256'(32'h4444));
        chk("full_cfg7", 256'(reg_of(7)), 256'(32'h5555));

        // force_commit mid-frame, then with an empty FIFO
        wait_frame(4);
        push(3'd6, 32'h4000_0000);
        force_commit = 1'b1; cycle(); force_commit = 1'b0;
        chk("force_cfg6_old", 256'(reg_of(6)), 256'(32'h3E71_4120));
        chk("force_ready0", 256'(wr_ready), 256'(0));
        cycle();
        chk("force_cfg6_new", 256'(reg_of(6)), 256'(32'h4000_0000));
        chk("force_done", 256'(commit_done), 256'(1));
        chk("force_epoch", 256'(cfg_epoch), 256'(5));
        cycle();
        force_commit = 1'b1; cycle(); force_commit = 1'b0;
        repeat (2) begin
            cycle();
            chk("force_empty_done", 256'(commit_done), 256'(0));
            chk("force_empty_epoch", 256'(cfg_epoch), 256'(5));
        end

        // table of single-write forced commits
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].a, vecs[i].d);
            force_commit = 1'b1; cycle(); force_commit = 1'b0;
            wait_done();
            chk("vec_cfg", 256'(reg_of(int'(vecs[i].a))), 256'(vecs[i].exp));
        end

        // async reset on the second drain cycle
        wait_frame(2);
        for (int i = 0; i < 4; i++) push(3'(i), 32'hA000_0000 + 32'(i));
        wait_frame(0);
        cycle();
        #2 reset_global = 1'b1;
        #1 model_reset();
        for (int i = 0; i < 8; i++) chk("rst_mid_cfg", 256'(reg_of(int'(defs[i].a))), 256'(defs[i].exp));
        chk("rst_mid_pending", 256'(pending_cnt), 256'(0));
        chk("rst_mid_done", 256'(commit_done), 256'(0));
        chk("rst_mid_epoch", 256'(cfg_epoch), 256'(0));
        #1 reset_global = 1'b0;
        cycle();
        chk("rst_after_done", 256'(commit_done), 256'(0));
        push(3'd4, 32'h4100_0000);
        wait_done();
        chk("rst_after_epoch", 256'(cfg_epoch), 256'(1));
        chk("rst_after_cfg4", 256'(reg_of(4)), 256'(32'h4100_0000));

        // randomized traffic against the model, long enough to wrap cfg_epoch
        for (int c = 0; c < 6000; c++) begin
            if (!wr_valid || m_push) begin
                wr_valid = ($urandom_range(0, 9) < 6);
                wr_addr  = 3'($urandom_range(0, 7));
                wr_data  = $urandom;
            end
            force_commit = ($urandom_range(0, 7) == 0);
            cycle();
        end
        wr_valid = 1'b0; force_commit = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
